// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the DMA transfer engine.
//   dma_state_e    - transfer FSM states
//   AXI_* consts   - AXI response / size / burst encodings; the size, burst,
//                    ID and write-strobe tie-offs are applied at the wrapper.
//   burst_beats()  - beats in the next burst, min(remaining, max_burst)
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5,
    DONE  = 3'd6
  } dma_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // max_burst is at most 16, so the result always fits in 5 bits.
  function automatic logic [4:0] burst_beats(input logic [31:0] rem,
                                             input int max_burst);
    return (rem >= 32'(max_burst)) ? 5'(max_burst) : rem[4:0];
  endfunction

endpackage

// File: rtl/dma_burst_buf.sv
// dma_burst_buf: synchronous FIFO holding one read burst until it is written.
//   clk, rst  - clock, asynchronous active-high reset (empties the buffer)
//   push, din - write one word
//   pop, dout - dout is the head word; pop removes it
//   empty     - no words stored
//   full      - DEPTH words stored
// Storage words are not reset; only pointers and the count are.
module dma_burst_buf #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The engine reads at most one burst before draining it.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: DMA copy engine. On dma_en it copies dma_len words from
// dma_src to dma_dst as repeated AXI4 INCR read bursts into a one-burst
// buffer, each followed by a write burst out of that buffer.
//   clk, rst            - clock, asynchronous active-high reset
//   dma_en/src/dst/len  - start request and transfer descriptor (sampled in IDLE)
//   dma_done            - level, high in DONE until dma_en drops
//   dma_err             - sticky error for the current transfer
//   M_AR*/M_R*          - AXI read address / data channels
//   M_AW*/M_W*/M_B*     - AXI write address / data / response channels
//   dbg_state           - current FSM state (dma_state_e encoding)
// Optional feature macro: DMA_ABORT_EN (dma_en=0 while busy aborts after the
// current burst; an abort seen in RADDR before its handshake ends at once).
//
// Handshake semantics: a beat transfers on a rising edge where valid && ready.
// Valid is asserted from a registered state and held with a stable payload
// until that edge; ready never depends on the partner's valid.
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_en,
  input  logic [31:0]       dma_src,
  input  logic [31:0]       dma_dst,
  input  logic [31:0]       dma_len,
  output logic              dma_done,
  output logic              dma_err,
  output logic [ADDR_W-1:0] M_ARAddr,
  output logic [3:0]        M_ARLen,
  output logic              M_ARValid,
  input  logic              M_ARReady,
  input  logic [DATA_W-1:0] M_RData,
  input  logic [1:0]        M_RResp,
  input  logic              M_RLast,
  input  logic              M_RValid,
  output logic              M_RReady,
  output logic [ADDR_W-1:0] M_AWAddr,
  output logic [3:0]        M_AWLen,
  output logic              M_AWValid,
  input  logic              M_AWReady,
  output logic [DATA_W-1:0] M_WData,
  output logic              M_WLast,
  output logic              M_WValid,
  input  logic              M_WReady,
  input  logic [1:0]        M_BResp,
  input  logic              M_BValid,
  output logic              M_BReady,
  output logic [2:0]        dbg_state
);

  localparam int BYTES = DATA_W / 8;

  dma_state_e        state, next_state;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [31:0]       rem;
  logic [4:0]        beat_cnt;
  logic              err;

  logic [4:0]        n;
  logic [ADDR_W-1:0] step;
  logic              last_beat;
  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic              buf_empty, buf_full;
  logic              abort;

  // rem only changes on the B handshake, so n is stable for a whole burst.
  assign n         = burst_beats(rem, MAX_BURST);
  assign step      = ADDR_W'(n) * ADDR_W'(BYTES);
  assign last_beat = (beat_cnt == n - 5'd1);

  assign ar_hs = M_ARValid && M_ARReady;
  assign r_hs  = M_RValid  && M_RReady;
  assign aw_hs = M_AWValid && M_AWReady;
  assign w_hs  = M_WValid  && M_WReady;
  assign b_hs  = M_BValid  && M_BReady;

`ifdef DMA_ABORT_EN
  logic abort_pend;
  assign abort = abort_pend || !dma_en;
`else
  assign abort = 1'b0;
`endif

  dma_burst_buf #(.DEPTH(MAX_BURST), .DATA_W(DATA_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (r_hs),
    .din   (M_RData),
    .pop   (w_hs),
    .dout  (M_WData),
    .empty (buf_empty),
    .full  (buf_full)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (dma_en) next_state = (dma_len == 32'd0) ? DONE : RADDR;
      // An accepted AR must be followed through; abort only wins before it.
      RADDR: if (ar_hs) next_state = RDATA;
             else if (abort) next_state = DONE;
      RDATA: if (r_hs && last_beat) next_state = WADDR;
      WADDR: if (aw_hs) next_state = WDATA;
      WDATA: if (w_hs && last_beat) next_state = WRESP;
      WRESP: if (b_hs) begin
               if (rem == 32'(n) || err || M_BResp != AXI_RESP_OKAY || abort)
                 next_state = DONE;
               else
                 next_state = RADDR;
             end
      DONE:  if (!dma_en) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      rem      <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (dma_en) begin
          src_ptr  <= ADDR_W'(dma_src);
          dst_ptr  <= ADDR_W'(dma_dst);
          rem      <= dma_len;
          beat_cnt <= '0;
          err      <= 1'b0;
        end
        RDATA: if (r_hs) begin
          beat_cnt <= last_beat ? 5'd0 : beat_cnt + 5'd1;
          // Early RLast is flagged but the engine still waits for n beats.
          if (M_RResp != AXI_RESP_OKAY || (M_RLast && !last_beat)) err <= 1'b1;
        end
        WDATA: if (w_hs) beat_cnt <= last_beat ? 5'd0 : beat_cnt + 5'd1;
        WRESP: if (b_hs) begin
          if (M_BResp != AXI_RESP_OKAY) err <= 1'b1;
          src_ptr <= src_ptr + step;
          dst_ptr <= dst_ptr + step;
          rem     <= rem - 32'(n);
        end
        default: ;
      endcase
    end
  end

`ifdef DMA_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      abort_pend <= 1'b0;
    else if (state == IDLE)
      abort_pend <= 1'b0;
    else if (state != DONE && !dma_en)
      abort_pend <= 1'b1;
  end
`endif

  assign M_ARValid = (state == RADDR);
  assign M_ARAddr  = src_ptr;
  assign M_ARLen   = (state == RADDR) ? 4'(n - 5'd1) : 4'd0;
  assign M_RReady  = (state == RDATA) && !buf_full;
  assign M_AWValid = (state == WADDR);
  assign M_AWAddr  = dst_ptr;
  assign M_AWLen   = (state == WADDR) ? 4'(n - 5'd1) : 4'd0;
  assign M_WValid  = (state == WDATA) && !buf_empty;
  assign M_WLast   = (state == WDATA) && !buf_empty && last_beat;
  assign M_BReady  = (state == WRESP);
  assign dma_done  = (state == DONE);
  assign dma_err   = err;
  assign dbg_state = state;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// tb_dma_xfer_ctrl: directed bench for dma_xfer_ctrl with an AXI slave model
// (memory pattern rd_fn, optional random stalls and read-error injection),
// a payload stability monitor and a write scoreboard.
module tb_dma_xfer_ctrl;

  logic        clk, rst;
  logic        dma_en;
  logic [31:0] dma_src, dma_dst, dma_len;
  logic        dma_done, dma_err;
  logic [31:0] M_ARAddr, M_AWAddr, M_RData, M_WData;
  logic [3:0]  M_ARLen, M_AWLen;
  logic        M_ARValid, M_ARReady, M_RLast, M_RValid, M_RReady;
  logic        M_AWValid, M_AWReady, M_WLast, M_WValid, M_WReady;
  logic        M_BValid, M_BReady;
  logic [1:0]  M_RResp, M_BResp;
  logic [2:0]  dbg_state;

  dma_xfer_ctrl dut (
    .clk(clk), .rst(rst), .dma_en(dma_en), .dma_src(dma_src), .dma_dst(dma_dst),
    .dma_len(dma_len), .dma_done(dma_done), .dma_err(dma_err),
    .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen), .M_ARValid(M_ARValid), .M_ARReady(M_ARReady),
    .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast), .M_RValid(M_RValid),
    .M_RReady(M_RReady), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen), .M_AWValid(M_AWValid),
    .M_AWReady(M_AWReady), .M_WData(M_WData), .M_WLast(M_WLast), .M_WValid(M_WValid),
    .M_WReady(M_WReady), .M_BResp(M_BResp), .M_BValid(M_BValid), .M_BReady(M_BReady),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- slave model state / logs ----------------
  logic        stall_en = 1'b0;
  int          err_burst = 0;   // 1-based read burst to corrupt, 0 = none
  int          err_beat  = 0;   // 0-based beat within that burst
  logic [31:0] ar_addr_log[$], aw_addr_log[$], w_addr_log[$], w_data_log[$];
  logic [3:0]  ar_len_log[$], aw_len_log[$];
  logic [31:0] exp_q[$], exp_a_q[$];
  int          wlast_err = 0;
  int          stab_err  = 0;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  // Read slave: sample handshakes at negedge, update outputs after posedge.
  initial begin : rd_slave
    logic        ar_hs_s, r_hs_s;
    logic [31:0] ar_a, rd_base;
    logic [3:0]  ar_l;
    int          rd_len, rd_beat, rd_idx;
    logic        rd_busy;
    M_ARReady = 1'b0; M_RValid = 1'b0; M_RData = '0; M_RResp = 2'b00; M_RLast = 1'b0;
    rd_busy = 1'b0; rd_base = '0; rd_len = 0; rd_beat = 0; rd_idx = 0;
    forever begin
      @(negedge clk);
      ar_hs_s = M_ARValid && M_ARReady;
      r_hs_s  = M_RValid && M_RReady;
      ar_a    = M_ARAddr;
      ar_l    = M_ARLen;
      @(posedge clk); #1;
      if (rst) begin
        M_ARReady = 1'b0; M_RValid = 1'b0; M_RLast = 1'b0; M_RResp = 2'b00; rd_busy = 1'b0;
      end else begin
        if (r_hs_s) begin
          rd_beat++;
          if (rd_beat > rd_len) rd_busy = 1'b0;
        end
        if (ar_hs_s) begin
          ar_addr_log.push_back(ar_a);
          ar_len_log.push_back(ar_l);
          rd_idx  = ar_addr_log.size();
          rd_base = ar_a; rd_len = int'(ar_l); rd_beat = 0; rd_busy = 1'b1;
        end
        if (!(M_RValid && !r_hs_s)) begin
          if (rd_busy && (!stall_en || $urandom_range(0, 2) != 0)) begin
            M_RValid = 1'b1;
            M_RData  = rd_fn(rd_base + 32'(rd_beat * 4));
            M_RLast  = (rd_beat == rd_len);
            M_RResp  = (rd_idx == err_burst && rd_beat == err_beat) ? 2'b10 : 2'b00;
          end else begin
            M_RValid = 1'b0; M_RLast = 1'b0; M_RResp = 2'b00;
          end
        end
        M_ARReady = !stall_en || ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Write slave: logs AW bursts and W beats, answers with OKAY responses.
  initial begin : wr_slave
    logic        aw_hs_s, w_hs_s, b_hs_s, w_l;
    logic [31:0] aw_a, w_d, wr_base;
    logic [3:0]  aw_l;
    int          wr_len, wr_beat;
    logic        b_pend;
    M_AWReady = 1'b0; M_WReady = 1'b0; M_BValid = 1'b0; M_BResp = 2'b00;
    wr_base = '0; wr_len = 0; wr_beat = 0; b_pend = 1'b0;
    forever begin
      @(negedge clk);
      aw_hs_s = M_AWValid && M_AWReady;
      w_hs_s  = M_WValid && M_WReady;
      b_hs_s  = M_BValid && M_BReady;
      aw_a = M_AWAddr; aw_l = M_AWLen; w_d = M_WData; w_l = M_WLast;
      @(posedge clk); #1;
      if (rst) begin
        M_AWReady = 1'b0; M_WReady = 1'b0; M_BValid = 1'b0; b_pend = 1'b0;
      end else begin
        if (b_hs_s) b_pend = 1'b0;
        if (aw_hs_s) begin
          aw_addr_log.push_back(aw_a);
          aw_len_log.push_back(aw_l);
          wr_base = aw_a; wr_len = int'(aw_l); wr_beat = 0;
        end
        if (w_hs_s) begin
          w_addr_log.push_back(wr_base + 32'(wr_beat * 4));
          w_data_log.push_back(w_d);
          if (w_l != (wr_beat == wr_len)) wlast_err++;
          if (wr_beat == wr_len) b_pend = 1'b1;
          wr_beat++;
        end
        if (!(M_BValid && !b_hs_s))
          M_BValid = b_pend && (!stall_en || $urandom_range(0, 2) != 0);
        M_BResp   = 2'b00;
        M_AWReady = !stall_en || ($urandom_range(0, 2) != 0);
        M_WReady  = !stall_en || ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Valid must hold with a stable payload until its handshake.
  initial begin : stab_mon
    logic p_arv, p_awv, p_wv;
    logic [31:0] p_ara, p_awa, p_wd;
    logic [3:0]  p_arl, p_awl;
    logic        p_wl;
    p_arv = 0; p_awv = 0; p_wv = 0; p_ara = 0; p_awa = 0; p_wd = 0;
    p_arl = 0; p_awl = 0; p_wl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_arv = 0; p_awv = 0; p_wv = 0;
      end else begin
        if (p_arv && (M_ARValid !== 1'b1 || M_ARAddr !== p_ara || M_ARLen !== p_arl)) stab_err++;
        if (p_awv && (M_AWValid !== 1'b1 || M_AWAddr !== p_awa || M_AWLen !== p_awl)) stab_err++;
        if (p_wv && (M_WValid !== 1'b1 || M_WData !== p_wd || M_WLast !== p_wl)) stab_err++;
        p_arv = M_ARValid && !M_ARReady; p_ara = M_ARAddr; p_arl = M_ARLen;
        p_awv = M_AWValid && !M_AWReady; p_awa = M_AWAddr; p_awl = M_AWLen;
        p_wv  = M_WValid && !M_WReady;   p_wd  = M_WData;  p_wl  = M_WLast;
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    ar_addr_log.delete(); ar_len_log.delete(); aw_addr_log.delete(); aw_len_log.delete();
    w_addr_log.delete(); w_data_log.delete();
    dma_src = s; dma_dst = d; dma_len = l; dma_en = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (dma_done !== 1'b1 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done"}, 64'(dma_done), 64'd1);
  endtask

  task automatic finish_xfer(input string tag);
    dma_en = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, 64'(dma_done), 64'd0);
    chk({tag, "_idle"}, 64'(dbg_state), 64'd0);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] s, input logic [31:0] d,
                              input int nw);
    exp_q.delete(); exp_a_q.delete();
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back(rd_fn(s + 32'(i * 4)));
      exp_a_q.push_back(d + 32'(i * 4));
    end
    chk({tag, "_wr_count"}, 64'(w_data_log.size()), 64'(nw));
    for (int i = 0; i < nw && i < w_data_log.size(); i++) begin
      chk($sformatf("%s_wdata[%0d]", tag, i), 64'(w_data_log[i]), 64'(exp_q[i]));
      chk($sformatf("%s_waddr[%0d]", tag, i), 64'(w_addr_log[i]), 64'(exp_a_q[i]));
    end
    chk({tag, "_wlast"}, 64'(wlast_err), 64'd0);
  endtask

  task automatic chk_ar(input string tag, input int i, input logic [31:0] a, input logic [3:0] l);
    if (i < ar_addr_log.size()) begin
      chk($sformatf("%s_araddr%0d", tag, i), 64'(ar_addr_log[i]), 64'(a));
      chk($sformatf("%s_arlen%0d", tag, i), 64'(ar_len_log[i]), 64'(l));
    end else chk($sformatf("%s_ar%0d_present", tag, i), 64'(ar_addr_log.size()), 64'(i + 1));
  endtask

  task automatic chk_aw(input string tag, input int i, input logic [31:0] a, input logic [3:0] l);
    if (i < aw_addr_log.size()) begin
      chk($sformatf("%s_awaddr%0d", tag, i), 64'(aw_addr_log[i]), 64'(a));
      chk($sformatf("%s_awlen%0d", tag, i), 64'(aw_len_log[i]), 64'(l));
    end else chk($sformatf("%s_aw%0d_present", tag, i), 64'(aw_addr_log.size()), 64'(i + 1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
    chk({tag, "_valids"}, 64'({M_ARValid, M_RReady, M_AWValid, M_WValid, M_WLast, M_BReady}), 64'd0);
    chk({tag, "_done_err"}, 64'({dma_done, dma_err}), 64'd0);
    chk({tag, "_addrs"}, 64'({M_ARAddr, M_AWAddr}), 64'd0);
    chk({tag, "_lens"}, 64'({M_ARLen, M_AWLen}), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1; dma_en = 1'b0; dma_src = '0; dma_dst = '0; dma_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: single 4-word burst, AR latency of one cycle.
    start(32'h1000, 32'h2000, 32'd4);
    chk("t1_arvalid_pre", 64'(M_ARValid), 64'd0);
    @(posedge clk); #1;
    chk("t1_arvalid", 64'(M_ARValid), 64'd1);
    chk("t1_araddr_live", 64'(M_ARAddr), 64'h1000);
    chk("t1_arlen_live", 64'(M_ARLen), 64'd3);
    wait_done("t1", 200);
    chk("t1_ar_count", 64'(ar_addr_log.size()), 64'd1);
    chk("t1_aw_count", 64'(aw_addr_log.size()), 64'd1);
    chk_ar("t1", 0, 32'h1000, 4'd3);
    chk_aw("t1", 0, 32'h2000, 4'd3);
    check_writes("t1", 32'h1000, 32'h2000, 4);
    chk("t1_err", 64'(dma_err), 64'd0);
    finish_xfer("t1");

    // T2: 37 words -> 16/16/5.
    start(32'h1000, 32'h3000, 32'd37);
    wait_done("t2", 1000);
    chk("t2_ar_count", 64'(ar_addr_log.size()), 64'd3);
    chk("t2_aw_count", 64'(aw_addr_log.size()), 64'd3);
    chk_ar("t2", 0, 32'h1000, 4'd15);
    chk_ar("t2", 1, 32'h1040, 4'd15);
    chk_ar("t2", 2, 32'h1080, 4'd4);
    chk_aw("t2", 0, 32'h3000, 4'd15);
    chk_aw("t2", 1, 32'h3040, 4'd15);
    chk_aw("t2", 2, 32'h3080, 4'd4);
    check_writes("t2", 32'h1000, 32'h3000, 37);
    chk("t2_err", 64'(dma_err), 64'd0);
    finish_xfer("t2");

    // T3: zero length, no bus activity.
    start(32'h7000, 32'h7800, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_done", 64'(dma_done), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_done_held", 64'(dma_done), 64'd1);
    chk("t3_no_ar", 64'(ar_addr_log.size()), 64'd0);
    chk("t3_no_aw", 64'(aw_addr_log.size()), 64'd0);
    finish_xfer("t3");

    // T4: SLVERR on beat 2 of burst 1 -> only burst 1 written.
    err_burst = 1; err_beat = 1;
    start(32'h5000, 32'h6000, 32'd20);
    wait_done("t4", 500);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_err", 64'(dma_err), 64'd1);
    chk("t4_ar_count", 64'(ar_addr_log.size()), 64'd1);
    chk("t4_aw_count", 64'(aw_addr_log.size()), 64'd1);
    chk_aw("t4", 0, 32'h6000, 4'd15);
    check_writes("t4", 32'h5000, 32'h6000, 16);
    finish_xfer("t4");
    chk("t4_err_sticky", 64'(dma_err), 64'd1);
    err_burst = 0;

    // T5: random stalls on all channels.
    stall_en = 1'b1;
    start(32'h8000, 32'h9000, 32'd16);
    @(posedge clk); #1;
    chk("t5_err_cleared", 64'(dma_err), 64'd0);
    wait_done("t5", 3000);
    chk("t5_ar_count", 64'(ar_addr_log.size()), 64'd1);
    chk("t5_aw_count", 64'(aw_addr_log.size()), 64'd1);
    check_writes("t5", 32'h8000, 32'h9000, 16);
    chk("t5_stable", 64'(stab_err), 64'd0);
    chk("t5_err", 64'(dma_err), 64'd0);
    stall_en = 1'b0;
    finish_xfer("t5");

    // T6: reset in the middle of the write burst, then a clean transfer.
    start(32'h1000, 32'h2000, 32'd16);
    n = 0;
    while (w_data_log.size() < 3 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_in_wdata", 64'(dbg_state), 64'd4);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_rst");
    dma_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start(32'h1100, 32'h2200, 32'd4);
    wait_done("t6", 200);
    chk("t6_ar_count", 64'(ar_addr_log.size()), 64'd1);
    chk_ar("t6", 0, 32'h1100, 4'd3);
    chk_aw("t6", 0, 32'h2200, 4'd3);
    check_writes("t6", 32'h1100, 32'h2200, 4);
    chk("t6_err", 64'(dma_err), 64'd0);
    finish_xfer("t6");

`ifdef DMA_ABORT_EN
    // T7: abort during burst 1 of 48 words.
    start(32'hA000, 32'hB000, 32'd48);
    repeat (6) @(posedge clk);
    #1;
    dma_en = 1'b0;
    wait_done("t7", 500);
    repeat (20) @(posedge clk);
    #1;
    chk("t7_ar_count", 64'(ar_addr_log.size()), 64'd1);
    chk("t7_aw_count", 64'(aw_addr_log.size()), 64'd1);
    check_writes("t7", 32'hA000, 32'hB000, 16);
    chk("t7_idle", 64'(dbg_state), 64'd0);
    chk("t7_err", 64'(dma_err), 64'd0);
`endif

    chk("final_stable", 64'(stab_err), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
